// File: rtl/window_mac_stage.sv
// window_mac_stage: 2x2 window multiply-accumulate filter stage.
// Each accepted window is weighted by four signed 8-bit coefficients, summed,
// floor-shifted, clamped to the pixel range and queued in a first-word
// fall-through output FIFO. Admission is credit based: a window is taken only
// when the FIFO can hold every result already in the pipeline plus this one.
// Because of that, the three pipeline stages never need to stall.
module window_mac_stage #(
  parameter int DATA_W     = 32,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int ROW_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tstart,
  input  logic [31:0]           coef,
  input  logic                  win_valid,
  output logic                  win_ready,
  input  logic [4*DATA_W-1:0]   win,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last
);

  localparam int PW  = DATA_W + 9;   // one product
  localparam int SW  = DATA_W + 11;  // sum of four products
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;       // FIFO occupancy, 0..FIFO_DEPTH
  localparam int UW  = CW + 1;       // occupancy plus in-flight results
  localparam int RW  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

  localparam logic signed [SW-1:0] PIX_MAX = {{(SW-DATA_W){1'b0}}, {DATA_W{1'b1}}};
  localparam logic [RW-1:0]        ROW_END = RW'(ROW_LEN - 1);
  localparam logic [CW-1:0]        DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [UW-1:0]        DEPTH_U = UW'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                 state_q, state_d;
  logic signed [7:0]      k_q [4];
  logic signed [7:0]      k_d [4];

  logic                   v1_q, v2_q, v3_q;
  logic                   v1_d, v2_d, v3_d;
  logic signed [PW-1:0]   prod_q [4];
  logic signed [PW-1:0]   prod_d [4];
  logic signed [SW-1:0]   sum_q, sum_d;
  logic signed [SW-1:0]   shifted;
  logic [DATA_W-1:0]      s3_q, s3_d;

  logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [RW-1:0]          row_q, row_d;

  logic                   accept, push, pop;
  logic [1:0]             inflight;
  logic [UW-1:0]          credits_used;

  // Handshake and flow-control terms; win_ready depends only on state and counters.
  always_comb begin
    inflight     = 2'(v1_q) + 2'(v2_q) + 2'(v3_q);
    credits_used = UW'(count_q) + UW'(inflight);
    win_ready    = (state_q == ST_RUN) && (credits_used < DEPTH_U);
    accept       = win_valid && win_ready;
    out_valid    = (count_q != '0);
    out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
    out_last     = out_valid && (row_q == ROW_END);
    push         = v3_q;
    pop          = out_valid && out_ready;
  end

  // Control next state: FSM, coefficient latch, pipeline valids, FIFO pointers, row counter.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    k_d      = k_q;
    v1_d     = accept;
    v2_d     = v1_q;
    v3_d     = v2_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    row_d    = row_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      row_d    = (row_q == ROW_END) ? '0 : row_q + RW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A start pulse discards everything in flight or buffered, including a
    // window accepted on this very edge.
    if (tstart) begin
      state_d = ST_RUN;
      for (int i = 0; i < 4; i++) k_d[i] = $signed(coef[i*8 +: 8]);
      v1_d     = 1'b0;
      v2_d     = 1'b0;
      v3_d     = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      row_d    = '0;
    end
  end

  // Datapath next state: weight, sum, then floor-shift and clamp.
  always_comb begin
    for (int i = 0; i < 4; i++)
      prod_d[i] = PW'($signed({1'b0, win[i*DATA_W +: DATA_W]})) * PW'(k_q[i]);
    sum_d   = SW'(prod_q[0]) + SW'(prod_q[1]) + SW'(prod_q[2]) + SW'(prod_q[3]);
    shifted = sum_q >>> SHIFT;
    if (shifted[SW-1])
      s3_d = '0;
    else if (shifted > PIX_MAX)
      s3_d = '1;
    else
      s3_d = shifted[DATA_W-1:0];
  end

  // Control registers with synchronous reset; reset wins over a start pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q  <= ST_IDLE;
      for (int i = 0; i < 4; i++) k_q[i] <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      row_q    <= row_d;
    end
  end

  // Pipeline data and FIFO storage; qualified by the valid bits and count above.
  always_ff @(posedge clk) begin
    // NOTE: data registers and FIFO storage are not reset; nothing reads them unless a valid qualifies them.
    prod_q <= prod_d;
    sum_q  <= sum_d;
    s3_q   <= s3_d;
    if (push && !tstart) mem_q[wr_ptr_q] <= s3_q;
  end

  // Credits must make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!rst && !tstart)
      assert (!(push && count_q == DEPTH_C)) else $error("push into full output FIFO");
  end

endmodule

// File: tb/tb_window_mac_stage.sv
// Self-checking bench for window_mac_stage. A queue-based reference model
// holds one expected pixel per accepted window, computed from the filter
// arithmetic with plain integer math, and is compared at every output handshake.
module tb_window_mac_stage;

  localparam int DATA_W     = 32;
  localparam int SHIFT      = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int ROW_LEN    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          tstart;
  logic [31:0]   coef;
  logic          win_valid;
  logic          win_ready;
  logic [127:0]  win;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;

  window_mac_stage #(
    .DATA_W(DATA_W), .SHIFT(SHIFT), .FIFO_DEPTH(FIFO_DEPTH), .ROW_LEN(ROW_LEN)
  ) dut (
    .clk(clk), .rst(rst), .tstart(tstart), .coef(coef),
    .win_valid(win_valid), .win_ready(win_ready), .win(win),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          n_acc = 0;
  int          first_acc = -1, first_val = -1, first_pop = -1, last_pop = -1;
  logic [31:0] exp_q [$];
  logic [31:0] pop_log [$];
  bit          last_log [$];
  int          row_m  = 0;
  bit          run_m  = 0;
  logic [31:0] coef_m = '0;
  bit          acc_now = 0;
  bit          hold_pending = 0;
  logic [31:0] hold_data;
  logic        hold_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pixel: weighted sum, floor division by 2^SHIFT, clamp to pixel range.
  function automatic logic [31:0] ref_pix(input logic [127:0] w, input logic [31:0] k);
    longint acc = 0;
    longint px, kk, div, q;
    for (int i = 0; i < 4; i++) begin
      px  = longint'({32'b0, w[i*32 +: 32]});
      kk  = longint'($signed(k[i*8 +: 8]));
      acc = acc + px * kk;
    end
    div = longint'(1) << SHIFT;
    q   = acc / div;
    if ((acc % div != 0) && (acc < 0)) q = q - 1;
    if (q < 0) return 32'd0;
    if (q > 64'sd4294967295) return 32'hFFFF_FFFF;
    return q[31:0];
  endfunction

  // One clock: observe and check at the falling edge, update the model, step past the rising edge.
  task automatic cycle();
    @(negedge clk);
    acc_now = 0;
    if (hold_pending) begin
      check("hold_data", out_data, hold_data);
      check("hold_last", out_last, hold_last);
    end
    hold_pending = 0;
    check("win_ready", win_ready, run_m && (exp_q.size() < FIFO_DEPTH));
    if (exp_q.size() == 0) check("no_result_pending", out_valid, 0);
    if (!out_valid) check("last_without_valid", out_last, 0);
    if (out_valid && first_val < 0) first_val = cyc;
    if (out_valid && out_ready && exp_q.size() != 0) begin
      check("out_data", out_data, exp_q[0]);
      check("out_last", out_last, row_m == ROW_LEN - 1);
      void'(exp_q.pop_front());
      row_m = (row_m + 1) % ROW_LEN;
      pop_log.push_back(out_data);
      last_log.push_back(out_last);
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end else if (out_valid && !out_ready) begin
      hold_pending = !rst && !tstart;
      hold_data    = out_data;
      hold_last    = out_last;
    end
    if (win_valid && win_ready) begin
      acc_now = 1;
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
      exp_q.push_back(ref_pix(win, coef_m));
    end
    if (rst) begin
      exp_q.delete();
      row_m = 0; run_m = 0; coef_m = '0; hold_pending = 0;
    end else if (tstart) begin
      exp_q.delete();
      row_m = 0; run_m = 1; coef_m = coef; hold_pending = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic start_pulse(input logic [31:0] k);
    coef = k; tstart = 1'b1;
    cycle();
    tstart = 1'b0; coef = '0;
  endtask

  task automatic send_window(input logic [127:0] w);
    int budget = 0;
    win = w; win_valid = 1'b1;
    do begin cycle(); budget++; end while (!acc_now && budget < 50);
    check("send_accept_timeout", acc_now, 1);
    win_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin cycle(); n++; end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] rand_pix();
    return ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 255));
  endfunction

  initial begin
    int n0, np;
    rst = 1'b1; tstart = 1'b0; coef = '0; win_valid = 1'b0; win = '0; out_ready = 1'b0;

    // Reset state and IDLE behaviour.
    repeat (2) cycle();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_win_ready", win_ready, 0);
    win_valid = 1'b1; win = {4{32'd9}};
    repeat (3) cycle();
    win_valid = 1'b0;

    // Identity filter, back to back, latency and throughput.
    start_pulse(32'h0000_0001);
    check("run_win_ready", win_ready, 1);
    out_ready = 1'b1;
    first_acc = -1; first_val = -1; first_pop = -1;
    pop_log.delete(); last_log.delete();
    for (int i = 1; i <= 10; i++) begin
      win = {96'b0, 32'(4 * i)}; win_valid = 1'b1;
      cycle();
    end
    win_valid = 1'b0;
    drain(30);
    check("id_latency", first_val - first_acc, 4);
    check("id_count", pop_log.size(), 10);
    check("id_span", last_pop - first_pop, 9);
    for (int i = 0; i < pop_log.size(); i++) check("id_data", pop_log[i], i + 1);

    // Box filter including a floor case.
    start_pulse(32'h0101_0101);
    send_window({32'd16, 32'd12, 32'd8, 32'd4});
    drain(20);
    check("box_10", pop_log[$], 10);
    send_window({32'd2, 32'd1, 32'd1, 32'd1});
    drain(20);
    check("box_floor", pop_log[$], 1);

    // Clamping at both ends.
    start_pulse(32'hFFFF_FFFF);
    send_window({4{32'd5}});
    drain(20);
    check("clamp_low", pop_log[$], 0);
    start_pulse(32'h7F7F_7F7F);
    send_window({4{32'hFFFF_FFFF}});
    drain(20);
    check("clamp_high", pop_log[$], 32'hFFFF_FFFF);

    // Backpressure: exactly FIFO_DEPTH accepts, then drain in order.
    start_pulse(32'h0000_0001);
    out_ready = 1'b0;
    n0 = n_acc;
    for (int j = 0; j < 12; j++) begin
      win = {96'b0, 32'(4 * (j + 1))}; win_valid = 1'b1;
      cycle();
    end
    win_valid = 1'b0;
    check("bp_accepts", n_acc - n0, FIFO_DEPTH);
    check("bp_ready_low", win_ready, 0);
    pop_log.delete();
    out_ready = 1'b1;
    cycle();
    check("bp_ready_back", win_ready, 1);
    drain(30);
    check("bp_count", pop_log.size(), FIFO_DEPTH);
    for (int i = 0; i < pop_log.size(); i++) check("bp_order", pop_log[i], i + 1);

    // Flush with three windows in flight and one accepted on the start edge.
    start_pulse($urandom());
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      win = {rand_pix(), rand_pix(), rand_pix(), rand_pix()}; win_valid = 1'b1;
      cycle();
    end
    coef = $urandom(); tstart = 1'b1;
    win = {rand_pix(), rand_pix(), rand_pix(), rand_pix()};
    cycle();
    tstart = 1'b0; win_valid = 1'b0;
    check("flush_valid_low", out_valid, 0);
    np = pop_log.size();
    repeat (8) cycle();
    check("flush_no_output", pop_log.size() - np, 0);
    pop_log.delete(); last_log.delete();
    for (int i = 0; i < ROW_LEN; i++) begin
      win = {rand_pix(), rand_pix(), rand_pix(), rand_pix()}; win_valid = 1'b1;
      cycle();
    end
    win_valid = 1'b0;
    drain(30);
    check("flush_row_count", last_log.size(), ROW_LEN);
    for (int i = 0; i < last_log.size(); i++) check("flush_row_last", last_log[i], i == ROW_LEN - 1);

    // Randomized traffic with random stalls; last markers on outputs 8 and 16.
    start_pulse($urandom());
    pop_log.delete(); last_log.delete();
    n0 = n_acc;
    for (int t = 0; t < 600 && pop_log.size() < 20; t++) begin
      win_valid = (n_acc - n0 < 20) && ($urandom_range(0, 3) != 0);
      win       = {rand_pix(), rand_pix(), rand_pix(), rand_pix()};
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    win_valid = 1'b0; out_ready = 1'b1;
    check("rand_count", pop_log.size(), 20);
    for (int i = 0; i < 20; i++)
      if (i < last_log.size()) check("rand_last_pos", last_log[i], (i == 7) || (i == 15));

    // Reset mid-stream, then recover with a start pulse.
    start_pulse(32'h0000_0001);
    for (int i = 0; i < 5; i++) begin
      win = {rand_pix(), rand_pix(), rand_pix(), rand_pix()}; win_valid = 1'b1;
      cycle();
    end
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_win_ready", win_ready, 0);
    repeat (3) cycle();
    win_valid = 1'b0;
    start_pulse(32'h0000_0001);
    send_window({96'b0, 32'd28});
    drain(20);
    check("recover_data", pop_log[$], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/window_mac_stage.md
# window_mac_stage

Downstream consumer of the line buffer's 2x2 window stream. Accepts one 2x2 window of unsigned pixels per handshake and multiplies each pixel by a signed 8-bit coefficient. It sums the four products, rounds by arithmetic right shift, clamps to the pixel range, and emits one filtered pixel per window. Results pass through an internal credit-protected output FIFO, so downstream stalls propagate as `win_ready` low upstream without data loss. Each output carries an end-of-row marker.

## Interface
Parameters:
- `DATA_W`, 32, pixel width (input and output)
- `SHIFT`, 2, right-shift applied to the accumulated sum
- `FIFO_DEPTH`, 8, output FIFO entries (power of two, ≥4)
- `ROW_LEN`, 8, outputs per row; drives `out_last`

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `tstart`  in  1  start pulse: arms block, samples `coef`, flushes state
- `coef`  in  32  four signed 8-bit coefficients: [7:0]=k00, [15:8]=k01, [23:16]=k10, [31:24]=k11
- `win_valid`  in  1  window valid from line buffer
- `win_ready`  out  1  block can accept a window
- `win`  in  4*DATA_W  window: [DATA_W-1:0]=w00, then w01, w10, w11 upward
- `out_valid`  out  1  result available
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  DATA_W  filtered pixel
- `out_last`  out  1  result is last of its row

## Operation
- States:
  - IDLE: after `rst`. `win_ready`=0. `tstart`=1 → RUN.
  - RUN: remains until `rst`.
- Actions on `tstart`:
  - Latch `coef` into coefficient registers.
  - Clear pipeline valid bits, FIFO pointers and count, and the row counter.
  - Any in-flight or buffered results are discarded, in any state.
- A window is accepted on an edge where `win_valid && win_ready`.
- Arithmetic:
  - Each product is `w` (zero-extended) × `k` (signed), DATA_W+9 bits signed.
  - The sum of the four products is DATA_W+11 bits signed.
  - The sum is arithmetic-shifted right by `SHIFT` (floor).
  - The result is clamped: negative → 0; > 2^DATA_W−1 → 2^DATA_W−1.
- Pipeline:
  - S1 registers the 4 products.
  - S2 registers the sum.
  - S3 registers the shifted, clamped value and pushes it to the FIFO.
  - Stages advance unconditionally; credits guarantee FIFO space.
- Flow control:
  - inflight = number of valid S1..S3 stages (0..3).
  - `win_ready` = RUN && (fifo_count + inflight < FIFO_DEPTH).
  - `win_ready` is registered-free combinational from state and counters only; it does not depend on `win_valid`.
- FIFO:
  - First-word fall-through.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop occurs on `out_valid && out_ready`.
  - Push at full cannot occur; an assertion flags it.
- Row counter:
  - Counts output handshakes modulo ROW_LEN.
  - `out_last` = 1 when counter == ROW_LEN−1 while `out_valid` is high.
  - The counter wraps to 0 on that handshake.
- `out_data` and `out_last` are held stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `win_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0.
  - Coefficients = 0; counters and pointers = 0.
- `rst` has priority over `tstart` in the same cycle; the block stays in IDLE.
- The earliest window acceptance is the edge after the one that samples `tstart`.
- Latency: window accepted at edge N → S3 value written at edge N+3 → `out_valid`=1 in the cycle after edge N+3 (FIFO previously empty).
- Throughput: 1 window/cycle sustained while `out_ready`=1.
- Stall: with `out_ready` held 0, exactly FIFO_DEPTH windows are accepted, then `win_ready`=0.
- `win_ready` reasserts the cycle after the first pop.
- `tstart` mid-stream:
  - `out_valid`=0 the cycle after the edge that samples `tstart`.
  - Results of windows accepted before that edge never appear.
  - A window accepted on the `tstart` edge itself is discarded.

## Test plan
- Reset: assert `rst` 2 cycles mid-stream → all outputs 0 next cycle; `win_ready` stays 0 until `tstart`.
- Identity: coef k00=1, others 0, SHIFT=2, `out_ready`=1. Windows with w00=4,8,…,40 sent back to back → outputs 1,2,…,10, first `out_valid` 4 cycles after first accept, one per cycle.
- Box filter: all k=1, SHIFT=2. Window (4,8,12,16) → 10. Window (1,1,1,2) → 1 (floor).
- Clamp:
  - all k=−1, window (5,5,5,5) → 0.
  - all k=127, window all 2^32−1 → 2^32−1.
- Backpressure: `out_ready`=0, `win_valid`=1 with incrementing data → `win_ready` drops after 8 accepts. Raising `out_ready` drains those 8 in order, with no loss or duplication, and `win_ready` returns.
- Row/flush:
  - ROW_LEN=8, 20 outputs → `out_last` on outputs 8 and 16 only.
  - `tstart` pulsed with 3 windows in flight → none emerge; the next output's `out_last` count restarts at 1.
